bcd_updown_counter: RTL and testbench



---
 rtl/bcd_updown_counter.sv | 173 +++++++++++++++++
 tb/tb_bcd_updown_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// N-digit BCD up/down counter that drives the seven-segment digit decoders.
// It supports count up and down, a synchronous clear, an optional parallel
// load, and a wrap or saturate limit mode. It also has an optional clock-style
// radix: odd digits count 0-5 so that mm:ss / hh:mm:ss displays work.
//
// Parameters:
//   BCD_NUM   - number of digits (1..16)
//   TIME_MODE - 0: all digits radix 10; 1: odd-index digits radix 6
//   WRAP      - 1: wrap at the limits; 0: saturate at the limits
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   incr / decr   in   single-cycle step strobes (both high = no step)
//   reset_counter in   synchronous clear of the count
//   load          in   parallel-load strobe (only with the load macro)
//   load_bcds     in   value to load, one nibble per digit
//   bcds          out  registered count, index 0 least significant
//   carry         out  one-cycle pulse on a wrap or a blocked saturating step
//   at_zero       out  count is all zeros
//   at_max        out  every digit is at its maximum
//
// Build option:
//   BCD_UPDOWN_COUNTER_LOAD_EN - when defined, compiles in the parallel load
//   path and the per-digit clamp. When undefined, load and load_bcds are
//   ignored and the command priority is reset > reset_counter > step.
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter int BCD_NUM   = 8,
    parameter int TIME_MODE = 0,
    parameter int WRAP      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       incr,
    input  logic       decr,
    input  logic       reset_counter,
    input  logic       load,
    input  logic [3:0] load_bcds [BCD_NUM],
    output logic [3:0] bcds      [BCD_NUM],
    output logic       carry,
    output logic       at_zero,
    output logic       at_max
);

    // Largest legal value of digit idx.
    function automatic logic [3:0] dmax(input int idx);
        if (TIME_MODE == 1 && (idx % 2) == 1) begin
            return 4'd5;
        end
        return 4'd9;
    endfunction

    logic [3:0] bcds_q  [BCD_NUM];
    logic [3:0] bcds_d  [BCD_NUM];
    logic [3:0] up_bcds [BCD_NUM];
    logic [3:0] dn_bcds [BCD_NUM];
    logic       carry_q;
    logic       carry_d;
    logic       up_ovf;
    logic       dn_ovf;

    // Ripple the +1 and -1 through the digits. A digit only changes while
    // the borrow/carry chain is still live. A chain that is still live past
    // the top digit means the count crossed full scale or zero. In that case
    // the up result is already all zeros and the down result is already full
    // scale, which are exactly the wrapped values.
    always_comb begin : ripple
        logic up_c;
        logic dn_c;
        up_c = 1'b1;
        dn_c = 1'b1;
        for (int i = 0; i < BCD_NUM; i++) begin
            up_bcds[i] = bcds_q[i];
            dn_bcds[i] = bcds_q[i];
            if (up_c) begin
                if (bcds_q[i] == dmax(i)) begin
                    up_bcds[i] = 4'd0;
                end else begin
                    up_bcds[i] = bcds_q[i] + 4'd1;
                    up_c       = 1'b0;
                end
            end
            if (dn_c) begin
                if (bcds_q[i] == 4'd0) begin
                    dn_bcds[i] = dmax(i);
                end else begin
                    dn_bcds[i] = bcds_q[i] - 4'd1;
                    dn_c       = 1'b0;
                end
            end
        end
        up_ovf = up_c;
        dn_ovf = dn_c;
    end

    // Command priority: reset_counter > load > single-direction step.
    // A step that overflows in saturate mode keeps the count but still
    // reports the blocked step on carry.
    always_comb begin
        for (int i = 0; i < BCD_NUM; i++) begin
            bcds_d[i] = bcds_q[i];
        end
        carry_d = 1'b0;
        if (reset_counter) begin
            for (int i = 0; i < BCD_NUM; i++) begin
                bcds_d[i] = 4'd0;
            end
`ifdef BCD_UPDOWN_COUNTER_LOAD_EN
        end else if (load) begin
            for (int i = 0; i < BCD_NUM; i++) begin
                bcds_d[i] = (load_bcds[i] > dmax(i)) ? dmax(i) : load_bcds[i];
            end
`endif
        end else if (incr ^ decr) begin
            if (incr) begin
                carry_d = up_ovf;
                if (!(up_ovf && WRAP == 0)) begin
                    bcds_d = up_bcds;
                end
            end else begin
                carry_d = dn_ovf;
                if (!(dn_ovf && WRAP == 0)) begin
                    bcds_d = dn_bcds;
                end
            end
        end
    end

`ifndef BCD_UPDOWN_COUNTER_LOAD_EN
    // The load port exists only for port-list compatibility in this build.
    logic unused_load_inputs;
    always_comb begin
        unused_load_inputs = load;
        for (int i = 0; i < BCD_NUM; i++) begin
            unused_load_inputs = unused_load_inputs ^ (^load_bcds[i]);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BCD_NUM; i++) begin
                bcds_q[i] <= 4'd0;
            end
            carry_q <= 1'b0;
        end else begin
            bcds_q  <= bcds_d;
            carry_q <= carry_d;
        end
    end

    // Status flags decode the registered count.
    always_comb begin
        at_zero = 1'b1;
        at_max  = 1'b1;
        for (int i = 0; i < BCD_NUM; i++) begin
            if (bcds_q[i] != 4'd0) begin
                at_zero = 1'b0;
            end
            if (bcds_q[i] != dmax(i)) begin
                at_max = 1'b0;
            end
        end
    end

    assign bcds  = bcds_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Five counters share one set of control strobes:
//   inst0: 2 digits, radix 10,    wrap
//   inst1: 4 digits, clock radix, wrap
//   inst2: 4 digits, clock radix, saturate
//   inst3: 4 digits, radix 10,    wrap
//   inst4: 4 digits, radix 10,    saturate
// A mixed-radix integer model predicts each counter's state. It predicts
// {carry, at_zero, at_max, digits}, queues the prediction when a command is
// driven, and pops and compares it one edge later.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

    localparam int NI = 5;
    localparam int W  = 19;

`ifdef BCD_UPDOWN_COUNTER_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, incr, decr, reset_counter, load;
    logic [3:0] ld4 [4];
    logic [3:0] ld2 [2];

    logic [3:0] b0 [2];
    logic [3:0] b1 [4];
    logic [3:0] b2 [4];
    logic [3:0] b3 [4];
    logic [3:0] b4 [4];
    logic [NI-1:0] c, z, m;

    assign ld2[0] = ld4[0];
    assign ld2[1] = ld4[1];

    bcd_updown_counter #(.BCD_NUM(2), .TIME_MODE(0), .WRAP(1)) u0 (
        .clk(clk), .reset(reset), .incr(incr), .decr(decr),
        .reset_counter(reset_counter), .load(load), .load_bcds(ld2),
        .bcds(b0), .carry(c[0]), .at_zero(z[0]), .at_max(m[0]));
    bcd_updown_counter #(.BCD_NUM(4), .TIME_MODE(1), .WRAP(1)) u1 (
        .clk(clk), .reset(reset), .incr(incr), .decr(decr),
        .reset_counter(reset_counter), .load(load), .load_bcds(ld4),
        .bcds(b1), .carry(c[1]), .at_zero(z[1]), .at_max(m[1]));
    bcd_updown_counter #(.BCD_NUM(4), .TIME_MODE(1), .WRAP(0)) u2 (
        .clk(clk), .reset(reset), .incr(incr), .decr(decr),
        .reset_counter(reset_counter), .load(load), .load_bcds(ld4),
        .bcds(b2), .carry(c[2]), .at_zero(z[2]), .at_max(m[2]));
    bcd_updown_counter #(.BCD_NUM(4), .TIME_MODE(0), .WRAP(1)) u3 (
        .clk(clk), .reset(reset), .incr(incr), .decr(decr),
        .reset_counter(reset_counter), .load(load), .load_bcds(ld4),
        .bcds(b3), .carry(c[3]), .at_zero(z[3]), .at_max(m[3]));
    bcd_updown_counter #(.BCD_NUM(4), .TIME_MODE(0), .WRAP(0)) u4 (
        .clk(clk), .reset(reset), .incr(incr), .decr(decr),
        .reset_counter(reset_counter), .load(load), .load_bcds(ld4),
        .bcds(b4), .carry(c[4]), .at_zero(z[4]), .at_max(m[4]));

    // ---------------- model ----------------
    int mv [NI];
    int vectors    = 0;
    int miscompares = 0;
    int step_no    = 0;
    logic [NI*W-1:0] exp_q [$];

    function automatic int nd(input int k);
        return (k == 0) ? 2 : 4;
    endfunction
    function automatic bit tm(input int k);
        return (k == 1 || k == 2);
    endfunction
    function automatic bit wr(input int k);
        return (k != 2 && k != 4);
    endfunction
    function automatic int radix(input int k, input int i);
        return (tm(k) && (i % 2) == 1) ? 6 : 10;
    endfunction
    function automatic int full(input int k);
        int p = 1;
        for (int i = 0; i < nd(k); i++) p = p * radix(k, i);
        return p - 1;
    endfunction
    function automatic int load_value(input int k);
        int v = 0;
        int d;
        for (int i = nd(k) - 1; i >= 0; i--) begin
            d = int'(ld4[i]);
            if (d > radix(k, i) - 1) d = radix(k, i) - 1;
            v = v * radix(k, i) + d;
        end
        return v;
    endfunction
    function automatic logic [W-1:0] exp_word(input int k, input int v, input bit cy);
        logic [W-1:0] w;
        int t = v;
        w = '0;
        for (int i = 0; i < nd(k); i++) begin
            w[i*4 +: 4] = 4'(t % radix(k, i));
            t = t / radix(k, i);
        end
        w[18] = cy;
        w[17] = (v == 0);
        w[16] = (v == full(k));
        return w;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit rc, input bit ld, input bit inc, input bit dec,
                        input logic [3:0] l0, input logic [3:0] l1,
                        input logic [3:0] l2, input logic [3:0] l3);
        logic [NI*W-1:0] e;
        logic [NI*W-1:0] got;
        logic [W-1:0] obs [NI];
        bit cy;
        reset = r; reset_counter = rc; load = ld; incr = inc; decr = dec;
        ld4[0] = l0; ld4[1] = l1; ld4[2] = l2; ld4[3] = l3;
        e = '0;
        for (int k = 0; k < NI; k++) begin
            cy = 1'b0;
            if (r || rc) begin
                mv[k] = 0;
            end else if (LOAD_EN && ld) begin
                mv[k] = load_value(k);
            end else if (inc && !dec) begin
                if (mv[k] == full(k)) begin
                    cy = 1'b1;
                    if (wr(k)) mv[k] = 0;
                end else begin
                    mv[k] = mv[k] + 1;
                end
            end else if (dec && !inc) begin
                if (mv[k] == 0) begin
                    cy = 1'b1;
                    if (wr(k)) mv[k] = full(k);
                end else begin
                    mv[k] = mv[k] - 1;
                end
            end
            e[k*W +: W] = exp_word(k, mv[k], cy);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        obs[0] = {c[0], z[0], m[0], 8'h00, b0[1], b0[0]};
        obs[1] = {c[1], z[1], m[1], b1[3], b1[2], b1[1], b1[0]};
        obs[2] = {c[2], z[2], m[2], b2[3], b2[2], b2[1], b2[0]};
        obs[3] = {c[3], z[3], m[3], b3[3], b3[2], b3[1], b3[0]};
        obs[4] = {c[4], z[4], m[4], b4[3], b4[2], b4[1], b4[0]};
        got = exp_q.pop_front();
        for (int k = 0; k < NI; k++) begin
            vectors++;
            assert (obs[k] === got[k*W +: W]) else begin
                miscompares++;
                $error("FAIL inst%0d step%0d observed{c,z,m,bcd}=%h expected=%h",
                       k, step_no, obs[k], got[k*W +: W]);
            end
        end
    endtask

    task automatic cmd_incr(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset = 1'b1; incr = 1'b0; decr = 1'b0; reset_counter = 1'b0; load = 1'b0;
        for (int i = 0; i < 4; i++) ld4[i] = 4'd0;
        for (int k = 0; k < NI; k++) mv[k] = 0;

        // reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0);
        // ten increments: 2-digit counter reads 10, no carry
        cmd_incr(10);
        // clear then step down from zero: wrap to full scale or saturate
        step(0, 1, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // climb to 5959 on the clock-radix counters, then step past it
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cmd_incr(3599);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // incr and decr together at 0042: no step, no carry
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cmd_incr(42);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0);
        // reset_counter beats load and incr
        step(0, 1, 1, 1, 0, 4'd4, 4'd3, 4'd2, 4'd1);
        // clamped load of 15,12,7,3
        step(0, 0, 1, 0, 0, 4'd15, 4'd12, 4'd7, 4'd3);
        // load coincident with incr
        step(0, 0, 1, 1, 0, 4'd9, 4'd5, 4'd9, 4'd5);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        // three increments, then reset coincident with a fourth
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cmd_incr(3);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // random back-to-back commands
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
